// File: rtl/vend_pkg.sv
// Shared types, coin/price encodings and helpers for the vending transaction controller.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } vend_state_e;

   localparam logic [1:0] COIN_1   = 2'b00;
   localparam logic [1:0] COIN_2   = 2'b01;
   localparam logic [1:0] COIN_5   = 2'b10;
   localparam logic [1:0] COIN_INV = 2'b11;

   localparam logic [3:0] PRICE_ITEM0 = 4'd5;
   localparam logic [3:0] PRICE_ITEM1 = 4'd7;
   localparam logic [3:0] PRICE_ITEM2 = 4'd10;
   localparam logic [3:0] PRICE_ITEM3 = 4'd12;

   localparam logic [3:0] CREDIT_MAX = 4'd15;

   function automatic logic [3:0] coin_units(input logic [1:0] code);
      logic [3:0] units;
      case (code)
         COIN_1:  units = 4'd1;
         COIN_2:  units = 4'd2;
         COIN_5:  units = 4'd5;
         default: units = 4'd0;
      endcase
      return units;
   endfunction

   // Greedy refund: largest coin that still fits in the remaining credit.
   function automatic logic [1:0] change_coin_for(input logic [3:0] credit);
      logic [1:0] code;
      if (credit >= 4'd5) begin
         code = COIN_5;
      end else if (credit >= 4'd2) begin
         code = COIN_2;
      end else begin
         code = COIN_1;
      end
      return code;
   endfunction

endpackage

// File: rtl/vend_if.sv
// Coin, selection, dispense and change-hopper signals of the vending controller.
interface vend_if;
   import vend_pkg::*;

   logic       coin_valid;
   logic [1:0] coin_value;
   logic       coin_accept;
   logic       coin_reject;
   logic       sel_valid;
   logic [1:0] item_code;
   logic       cancel;
   logic       sel_short;
   logic       dispense_req;
   logic [1:0] dispense_item;
   logic       dispense_ack;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       change_ready;
   logic [3:0] credit;
   logic       busy;

   modport slave (
      input  coin_valid, coin_value, sel_valid, item_code, cancel,
             dispense_ack, change_ready,
      output coin_accept, coin_reject, sel_short, dispense_req, dispense_item,
             change_valid, change_coin, credit, busy
   );

   modport master (
      output coin_valid, coin_value, sel_valid, item_code, cancel,
             dispense_ack, change_ready,
      input  coin_accept, coin_reject, sel_short, dispense_req, dispense_item,
             change_valid, change_coin, credit, busy
   );

endinterface

// File: rtl/vend_price_lut.sv
// Item code to price mapping; the single source of item prices.
module vend_price_lut
   import vend_pkg::*;
(
   input  logic [1:0] item_code_i,
   output logic [3:0] price_o
);

   // Combinational price lookup.
   always_comb begin
      case (item_code_i)
         2'b00:   price_o = PRICE_ITEM0;
         2'b01:   price_o = PRICE_ITEM1;
         2'b10:   price_o = PRICE_ITEM2;
         2'b11:   price_o = PRICE_ITEM3;
         default: price_o = PRICE_ITEM3;
      endcase
   end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction controller: coin credit, item selection, dispense handshake
// and greedy change payout; every output comes straight from a register.
module vend_txn_controller
   import vend_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
)
(
   input logic   clk,
   input logic   reset,
   vend_if.slave bus
);

   vend_state_e state_q, state_d;
   logic [3:0]  credit_q, credit_d;
   logic [15:0] tmo_q, tmo_d;
   logic [1:0]  item_q, item_d;
   logic        coin_acc_q, coin_acc_d;
   logic        coin_rej_q, coin_rej_d;
   logic        sel_short_q, sel_short_d;
   logic        disp_req_q, disp_req_d;
   logic        busy_q, busy_d;
   logic        chg_valid_q, chg_valid_d;
   logic [1:0]  chg_coin_q, chg_coin_d;
   logic [3:0]  price_s;
   logic [4:0]  coin_sum_s;
   logic        coin_open_s;

   vend_price_lut u_price_lut (
      .item_code_i (bus.item_code),
      .price_o     (price_s)
   );

   // Next-state, credit, timeout and registered-output computation.
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      tmo_d       = 16'd0;
      item_d      = item_q;
      coin_acc_d  = 1'b0;
      coin_rej_d  = 1'b0;
      sel_short_d = 1'b0;
      coin_open_s = ((state_q == ST_IDLE) || (state_q == ST_COLLECT)) && !bus.cancel;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_COLLECT: begin
            if (bus.cancel) begin
               state_d = (credit_q != 4'd0) ? ST_CHANGE : ST_IDLE;
            end else if (bus.sel_valid) begin
               if (credit_q >= price_s) begin
                  credit_d = credit_q - price_s;
                  item_d   = bus.item_code;
                  state_d  = ST_DISPENSE;
               end else begin
                  sel_short_d = 1'b1;
               end
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_DISPENSE: begin
            if (bus.dispense_ack) begin
               state_d = (credit_q != 4'd0) ? ST_CHANGE : ST_IDLE;
            end else begin
               state_d = ST_DISPENSE;
            end
         end
         ST_CHANGE: begin
            if (chg_valid_q && bus.change_ready) begin
               credit_d = credit_q - coin_units(chg_coin_q);
               state_d  = (credit_d == 4'd0) ? ST_IDLE : ST_CHANGE;
            end else begin
               state_d = ST_CHANGE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A coin lands on the credit left after any same-cycle purchase.
      coin_sum_s = {1'b0, credit_d} + {1'b0, coin_units(bus.coin_value)};
      if (bus.coin_valid && coin_open_s && (bus.coin_value != COIN_INV) &&
          (coin_sum_s <= {1'b0, CREDIT_MAX})) begin
         coin_acc_d = 1'b1;
         credit_d   = coin_sum_s[3:0];
      end else begin
         coin_rej_d = bus.coin_valid;
      end

      if (state_q == ST_IDLE) begin
         state_d = coin_acc_d ? ST_COLLECT : ST_IDLE;
      end else if ((state_q == ST_COLLECT) && (state_d == ST_COLLECT)) begin
         if (coin_acc_d) begin
            tmo_d = 16'd0;
         end else if (!bus.sel_valid && (tmo_q >= (TIMEOUT_CYCLES - 16'd1))) begin
            state_d = ST_CHANGE;
         end else begin
            tmo_d = tmo_q + 16'd1;
         end
      end else begin
         tmo_d = 16'd0;
      end

      disp_req_d  = (state_d == ST_DISPENSE);
      chg_valid_d = (state_d == ST_CHANGE);
      busy_d      = disp_req_d || chg_valid_d;
      chg_coin_d  = chg_valid_d ? change_coin_for(credit_d) : COIN_1;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         credit_q    <= 4'd0;
         tmo_q       <= 16'd0;
         item_q      <= 2'd0;
         coin_acc_q  <= 1'b0;
         coin_rej_q  <= 1'b0;
         sel_short_q <= 1'b0;
         disp_req_q  <= 1'b0;
         busy_q      <= 1'b0;
         chg_valid_q <= 1'b0;
         chg_coin_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         tmo_q       <= tmo_d;
         item_q      <= item_d;
         coin_acc_q  <= coin_acc_d;
         coin_rej_q  <= coin_rej_d;
         sel_short_q <= sel_short_d;
         disp_req_q  <= disp_req_d;
         busy_q      <= busy_d;
         chg_valid_q <= chg_valid_d;
         chg_coin_q  <= chg_coin_d;
      end
   end

   assign bus.coin_accept   = coin_acc_q;
   assign bus.coin_reject   = coin_rej_q;
   assign bus.sel_short     = sel_short_q;
   assign bus.dispense_req  = disp_req_q;
   assign bus.dispense_item = item_q;
   assign bus.change_valid  = chg_valid_q;
   assign bus.change_coin   = chg_coin_q;
   assign bus.credit        = credit_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench: per-cycle comparison against a transaction-level model plus
// directed scenarios with hand-computed expectations.
module tb_vend_txn_controller;
   import vend_pkg::*;

   localparam int T_OUT = 8;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   bit   chk_en;

   vend_if b ();

   vend_txn_controller #(.TIMEOUT_CYCLES(16'd8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: mode 0 idle, 1 collecting, 2 dispensing, 3 paying out the refund queue.
   int   m_mode, m_credit, m_idle, m_item;
   int   m_refund[$];
   logic e_acc, e_rej, e_short;

   function automatic int units_of(input logic [1:0] v);
      case (v)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 5;
         default: return 0;
      endcase
   endfunction

   function automatic int price_of(input logic [1:0] c);
      case (c)
         2'b00:   return 5;
         2'b01:   return 7;
         2'b10:   return 10;
         default: return 12;
      endcase
   endfunction

   function automatic logic [1:0] enc_of(input int u);
      if (u == 5) return 2'b10;
      if (u == 2) return 2'b01;
      return 2'b00;
   endfunction

   task automatic start_refund();
      int c;
      m_refund.delete();
      c = m_credit;
      while (c > 0) begin
         int u;
         u = (c >= 5) ? 5 : ((c >= 2) ? 2 : 1);
         m_refund.push_back(u);
         c -= u;
      end
      m_mode = (m_credit > 0) ? 3 : 0;
   endtask

   task automatic model_step();
      int  cv;
      bit  sold;
      bit  took;
      int  p;
      e_acc = 1'b0; e_rej = 1'b0; e_short = 1'b0;
      if (reset) begin
         m_mode = 0; m_credit = 0; m_idle = 0; m_item = 0;
         m_refund.delete();
      end else begin
         cv = units_of(b.coin_value);
         sold = 1'b0;
         took = 1'b0;
         if (m_mode == 1 && !b.cancel && b.sel_valid) begin
            p = price_of(b.item_code);
            if (m_credit >= p) begin
               m_credit -= p;
               m_item = int'(b.item_code);
               sold = 1'b1;
            end else begin
               e_short = 1'b1;
            end
         end
         if (b.coin_valid) begin
            if (m_mode <= 1 && !b.cancel && cv > 0 && m_credit + cv <= 15) begin
               m_credit += cv;
               took = 1'b1;
            end else begin
               e_rej = 1'b1;
            end
         end
         e_acc = took;
         case (m_mode)
            0: if (took) begin m_mode = 1; m_idle = 0; end
            1: begin
               if (b.cancel) start_refund();
               else if (sold) m_mode = 2;
               else if (took) m_idle = 0;
               else if (!b.sel_valid && m_idle == T_OUT - 1) start_refund();
               else m_idle++;
            end
            2: if (b.dispense_ack) start_refund();
            default: begin
               if (b.change_ready && m_refund.size() > 0) begin
                  m_credit -= m_refund.pop_front();
                  if (m_refund.size() == 0) m_mode = 0;
               end
            end
         endcase
      end
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: outputs registered at the last rising edge, then advance the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("coin_accept", 8'(b.coin_accept), 8'(e_acc));
         chk("coin_reject", 8'(b.coin_reject), 8'(e_rej));
         chk("sel_short", 8'(b.sel_short), 8'(e_short));
         chk("dispense_req", 8'(b.dispense_req), 8'(m_mode == 2));
         chk("dispense_item", 8'(b.dispense_item), 8'(m_item));
         chk("change_valid", 8'(b.change_valid), 8'(m_mode == 3));
         chk("busy", 8'(b.busy), 8'(m_mode == 2 || m_mode == 3));
         chk("credit", 8'(b.credit), 8'(m_credit));
         if (m_mode == 3 && m_refund.size() > 0)
            chk("change_coin", 8'(b.change_coin), 8'(enc_of(m_refund[0])));
      end
      model_step();
      chk_en = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input logic [1:0] v);
      b.coin_valid = 1'b1;
      b.coin_value = v;
      tick();
      b.coin_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((b.busy !== 1'b0 || b.credit !== 4'd0) && n < 40) begin
         tick();
         n++;
      end
      chk(nm, 8'(b.busy), 8'd0);
   endtask

   logic [1:0] seq36 [3];
   int         n_wait;

   initial begin
      n_vec = 0; n_err = 0; chk_en = 1'b0;
      seq36[0] = COIN_5; seq36[1] = COIN_2; seq36[2] = COIN_1;
      reset = 1'b1;
      b.coin_valid = 1'b0; b.coin_value = 2'b00; b.sel_valid = 1'b0;
      b.item_code = 2'b00; b.cancel = 1'b0; b.dispense_ack = 1'b0;
      b.change_ready = 1'b1;
      tick(); tick();
      chk("rst_credit", 8'(b.credit), 8'd0);
      chk("rst_busy", 8'(b.busy), 8'd0);
      chk("rst_change_valid", 8'(b.change_valid), 8'd0);
      chk("rst_dispense_req", 8'(b.dispense_req), 8'd0);
      reset = 1'b0;
      tick();

      // Coins 5,5,2 then item 10.
      coin(COIN_5); coin(COIN_5); coin(COIN_2);
      chk("s33_credit12", 8'(b.credit), 8'd12);
      b.sel_valid = 1'b1; b.item_code = 2'b10; tick(); b.sel_valid = 1'b0;
      chk("s33_dispense_req", 8'(b.dispense_req), 8'd1);
      chk("s33_credit2", 8'(b.credit), 8'd2);
      chk("s33_item", 8'(b.dispense_item), 8'd2);
      tick(); tick();
      chk("s33_req_held", 8'(b.dispense_req), 8'd1);
      b.dispense_ack = 1'b1; tick(); b.dispense_ack = 1'b0;
      chk("s33_change_coin", 8'(b.change_coin), 8'(COIN_2));
      tick();
      chk("s33_idle", 8'(b.change_valid), 8'd0);
      chk("s33_credit0", 8'(b.credit), 8'd0);

      // Ack and selection while idle are ignored; invalid coin rejected.
      b.dispense_ack = 1'b1; b.sel_valid = 1'b1; tick();
      b.dispense_ack = 1'b0; b.sel_valid = 1'b0;
      chk("idle_ignore_busy", 8'(b.busy), 8'd0);
      chk("idle_ignore_short", 8'(b.sel_short), 8'd0);
      coin(COIN_INV);
      chk("idle_coin11", 8'(b.coin_reject), 8'd1);

      // Insufficient credit.
      coin(COIN_5); coin(COIN_2);
      b.sel_valid = 1'b1; b.item_code = 2'b11; tick(); b.sel_valid = 1'b0;
      chk("s34_short", 8'(b.sel_short), 8'd1);
      chk("s34_credit7", 8'(b.credit), 8'd7);
      tick();
      chk("s34_short_once", 8'(b.sel_short), 8'd0);
      chk("s34_not_busy", 8'(b.busy), 8'd0);
      b.cancel = 1'b1; tick(); b.cancel = 1'b0;
      drain("s34_drain");

      // Overflowing and invalid coins.
      coin(COIN_5); coin(COIN_5); coin(COIN_2);
      coin(COIN_5);
      chk("s35_reject", 8'(b.coin_reject), 8'd1);
      chk("s35_credit12", 8'(b.credit), 8'd12);
      coin(COIN_INV);
      chk("s35_coin11", 8'(b.coin_reject), 8'd1);
      b.cancel = 1'b1; tick(); b.cancel = 1'b0;
      drain("s35_drain");

      // Cancel plus coin, stalled hopper.
      coin(COIN_5); coin(COIN_2); coin(COIN_1);
      chk("s36_credit8", 8'(b.credit), 8'd8);
      b.change_ready = 1'b0;
      b.cancel = 1'b1; b.coin_valid = 1'b1; b.coin_value = COIN_1; tick();
      b.cancel = 1'b0; b.coin_valid = 1'b0;
      chk("s36_reject", 8'(b.coin_reject), 8'd1);
      chk("s36_credit_kept", 8'(b.credit), 8'd8);
      coin(COIN_2);
      chk("s36_change_coin_rej", 8'(b.coin_reject), 8'd1);
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 3; s++) begin
            chk("s36_coin_held", 8'(b.change_coin), 8'(seq36[k]));
            tick();
         end
         chk("s36_coin", 8'(b.change_coin), 8'(seq36[k]));
         b.change_ready = 1'b1; tick(); b.change_ready = 1'b0;
      end
      chk("s36_done", 8'(b.change_valid), 8'd0);
      chk("s36_credit0", 8'(b.credit), 8'd0);
      b.change_ready = 1'b1;

      // Same-cycle selection and coin near the credit ceiling.
      coin(COIN_5); coin(COIN_5); coin(COIN_2); coin(COIN_2);
      b.sel_valid = 1'b1; b.item_code = 2'b00;
      b.coin_valid = 1'b1; b.coin_value = COIN_5; tick();
      b.sel_valid = 1'b0; b.coin_valid = 1'b0;
      chk("selcoin_accept", 8'(b.coin_accept), 8'd1);
      chk("selcoin_credit14", 8'(b.credit), 8'd14);
      chk("selcoin_disp", 8'(b.dispense_req), 8'd1);
      b.dispense_ack = 1'b1; tick(); b.dispense_ack = 1'b0;
      drain("selcoin_drain");

      coin(COIN_5); coin(COIN_5); coin(COIN_5);
      coin(COIN_1);
      chk("full_reject", 8'(b.coin_reject), 8'd1);
      b.sel_valid = 1'b1; b.item_code = 2'b11;
      b.coin_valid = 1'b1; b.coin_value = COIN_5; tick();
      b.sel_valid = 1'b0; b.coin_valid = 1'b0;
      chk("full_sel_credit8", 8'(b.credit), 8'd8);
      chk("full_sel_item", 8'(b.dispense_item), 8'd3);
      b.dispense_ack = 1'b1; tick(); b.dispense_ack = 1'b0;
      drain("full_drain");

      // Exact credit: dispense straight back to idle.
      coin(COIN_5);
      b.sel_valid = 1'b1; b.item_code = 2'b00; tick(); b.sel_valid = 1'b0;
      chk("exact_credit0", 8'(b.credit), 8'd0);
      b.dispense_ack = 1'b1; tick(); b.dispense_ack = 1'b0;
      chk("exact_no_change", 8'(b.change_valid), 8'd0);
      chk("exact_idle", 8'(b.busy), 8'd0);

      // Inactivity timeout with credit 3.
      coin(COIN_2); coin(COIN_1);
      b.change_ready = 1'b0;
      n_wait = 0;
      while (b.change_valid !== 1'b1 && n_wait < 20) begin
         tick();
         n_wait++;
      end
      chk("s37_latency", 8'(n_wait), 8'(T_OUT));
      chk("s37_coin2", 8'(b.change_coin), 8'(COIN_2));
      b.change_ready = 1'b1; tick();
      chk("s37_coin1", 8'(b.change_coin), 8'(COIN_1));
      tick();
      chk("s37_idle", 8'(b.change_valid), 8'd0);

      // Reset in the middle of a payout.
      coin(COIN_5); coin(COIN_1);
      b.change_ready = 1'b0;
      b.cancel = 1'b1; tick(); b.cancel = 1'b0;
      chk("s38_coin5", 8'(b.change_coin), 8'(COIN_5));
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("s38_credit0", 8'(b.credit), 8'd0);
      chk("s38_change_valid", 8'(b.change_valid), 8'd0);
      chk("s38_busy", 8'(b.busy), 8'd0);
      b.change_ready = 1'b1; tick();
      chk("s38_stays_idle", 8'(b.change_valid), 8'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vend_txn_controller.md
VEND_TXN_CONTROLLER -- requirements
Module: vend_txn_controller

Interface
REQ-001 TIMEOUT_CYCLES, 16'd1000, SHALL set the inactivity cycles in COLLECT before auto-refund.
REQ-002 clk  input  1  SHALL be the single rising-edge clock.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 coin_valid  input  1  SHALL mark a coin presented this cycle.
REQ-005 coin_value  input  2  SHALL encode the coin: 00=1, 01=2, 10=5, 11=invalid.
REQ-006 coin_accept / coin_reject  output  1 each  SHALL be registered one-cycle verdict pulses.
REQ-007 sel_valid  input  1  SHALL mark an item selection this cycle.
REQ-008 item_code  input  2  SHALL select the price: 00=5, 01=7, 10=10, 11=12.
REQ-009 cancel  input  1  SHALL request a refund of the current credit.
REQ-010 sel_short  output  1  SHALL pulse one cycle when a selection has insufficient credit.
REQ-011 dispense_req  output  1  / dispense_item  output  2  SHALL form the dispense request and the item latched for it.
REQ-012 dispense_ack  input  1  SHALL be the mechanism's completion acknowledge.
REQ-013 change_valid  output  1 / change_coin  output  2 / change_ready  input  1  SHALL form the valid/ready change-hopper handshake, using the coin encoding of REQ-005.
REQ-014 credit  output  4  SHALL show the current credit in units.
REQ-015 busy  output  1  SHALL be high in DISPENSE or CHANGE.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, DISPENSE and CHANGE.
REQ-017 A coin in IDLE/COLLECT SHALL be accepted if it is valid and credit+value<=15; otherwise it SHALL be rejected. Credit SHALL never wrap.
REQ-018 Any coin in DISPENSE/CHANGE, or coincident with cancel, SHALL be rejected.
REQ-019 An accepted coin in IDLE SHALL move the FSM to COLLECT.
REQ-020 In COLLECT, sel_valid with credit>=price SHALL:
- subtract price from credit;
- latch item_code into dispense_item;
- enter DISPENSE.
REQ-021 If credit<price, sel_valid SHALL pulse sel_short and leave state and credit unchanged.
REQ-022 Selection and coin in the same cycle:
- the selection is evaluated against the pre-coin credit;
- the coin is then accepted onto the post-selection credit if the sum <=15, else rejected.
REQ-023 Priority SHALL be cancel > sel_valid; sel_valid in IDLE SHALL be ignored.
REQ-024 dispense_req SHALL be high throughout DISPENSE. On dispense_ack sampled high, the FSM SHALL go to CHANGE if credit>0, else IDLE. dispense_ack outside DISPENSE SHALL be ignored.
REQ-025 cancel in COLLECT SHALL go to CHANGE if credit>0, else IDLE.
REQ-026 The timeout counter SHALL clear on entry to COLLECT and on every accepted coin. On reaching TIMEOUT_CYCLES-1 in COLLECT, the FSM SHALL go to CHANGE.
REQ-027 In CHANGE:
- change_coin SHALL be the largest of 5/2/1 that is <=credit;
- change_valid and change_coin SHALL stay stable until change_ready;
- each handshake SHALL subtract the coin from credit;
- credit reaching 0 SHALL return the FSM to IDLE with change_valid low.
REQ-028 All outputs SHALL be registered. The DISPENSE/CHANGE entry SHALL be visible the cycle after the triggering input.

Reset
REQ-029 While reset is high (sampled at clk), the block SHALL clear:
- state to IDLE;
- credit, timeout counter and dispense_item to 0;
- all output pulses and requests to 0.
REQ-030 Reset mid-DISPENSE or mid-CHANGE SHALL abort the transaction with no refund and no further handshake.

Structure
REQ-031 Package vend_pkg SHALL hold:
- the state enum;
- the coin encodings;
- the price constants 5/7/10/12;
- CREDIT_MAX=15.
REQ-032 Sub-module vend_price_lut SHALL map item_code to price combinationally and SHALL be the only price source.

Verification
REQ-033 After reset: coins 5,5,2 then sel item 10 -> credit 12→2, dispense_req until ack, then change_coin=2 once, then IDLE.
REQ-034 Credit 7, sel item 12 -> sel_short one pulse, credit stays 7, state COLLECT.
REQ-035 Credit 12, coin 5 -> coin_reject, credit 12. Coin 11 in any state -> coin_reject.
REQ-036 Credit 8, cancel plus coin in the same cycle -> coin_reject, then change 5,2,1 with change_ready stalled 3 cycles per coin and outputs held stable.
REQ-037 Credit 3 idle for TIMEOUT_CYCLES (set to 8) -> CHANGE emits 2 then 1.
REQ-038 Reset asserted during CHANGE with credit 6 -> next cycle IDLE, credit 0, change_valid 0.
